// File: rtl/uart_word_tx_if.sv
// Bundle between the word sequencer, its client and the uart core.
// master: client/uart side (word_in, send, uart_busy, rx_active); slave: sequencer.
interface uart_word_tx_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] word_in;
    logic                    send;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic                    send_dropped;
    logic [7:0]              tx_byte;
    logic                    tx_start;
    logic                    uart_busy;
    logic                    rx_active;

    modport master (
        output word_in, send, uart_busy, rx_active,
        input  busy, done, error, send_dropped, tx_byte, tx_start
    );

    modport slave (
        input  word_in, send, uart_busy, rx_active,
        output busy, done, error, send_dropped, tx_byte, tx_start
    );
endinterface

// File: rtl/uart_word_tx.sv
// Sends a latched WORD_BYTES word MSB byte first through the uart core, one frame per byte.
// Ports: clock, reset (async active-low), bus (slave: request/status + uart tx handshake).
module uart_word_tx #(
    parameter int WORD_BYTES  = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 1024
) (
    input logic           clock,
    input logic           reset,
    uart_word_tx_if.slave bus
);
    localparam int WB = 8 * WORD_BYTES;
    localparam int RW = $clog2(WORD_BYTES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [RW-1:0] R_FULL = RW'(WORD_BYTES);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
        DRAIN,
        GAP
    } state_t;

    state_t        state;
    logic [WB-1:0] shreg;
    logic [RW-1:0] remaining;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;
    logic          busy;
    logic          done;
    logic          error;
    logic          dropped;
    logic [7:0]    tx_byte;
    logic          tx_start;

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.error        = error;
    assign bus.send_dropped = dropped;
    assign bus.tx_byte      = tx_byte;
    assign bus.tx_start     = tx_start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            remaining <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            dropped   <= 1'b0;
            tx_byte   <= 8'h00;
            tx_start  <= 1'b0;
        end else begin
            done     <= 1'b0;
            error    <= 1'b0;
            tx_start <= 1'b0;
            // Any request that lands while a word is in flight is refused.
            dropped  <= bus.send && (state != IDLE);

            unique case (state)
                IDLE: begin
                    if (bus.send) begin
                        shreg     <= bus.word_in;
                        remaining <= R_FULL;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A frame still on the wire or an inbound frame holds us off.
                    if (!bus.uart_busy && !bus.rx_active) begin
                        tx_byte  <= shreg[WB-1 -: 8];
                        tx_start <= 1'b1;
                        timer    <= '0;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    if (bus.uart_busy) begin
                        state <= DRAIN;
                    end else if (timer == T_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!bus.uart_busy) begin
                        shreg     <= shreg << 8;
                        remaining <= remaining - 1'b1;
                        if (remaining == R_ONE) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (GAP_CYCLES > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == G_LAST) begin
                        state <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: three instances with simple uart core models.
// Ports: none; drives clock/reset and the master side of each interface.
module tb_uart_word_tx;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    uart_word_tx_if #(.WORD_BYTES(4)) ifa ();
    uart_word_tx_if #(.WORD_BYTES(1)) ifb ();
    uart_word_tx_if #(.WORD_BYTES(2)) ifc ();

    uart_word_tx #(.WORD_BYTES(4), .GAP_CYCLES(0), .ACK_TIMEOUT(16)) u_a (
        .clock(clock), .reset(reset), .bus(ifa.slave));
    uart_word_tx #(.WORD_BYTES(1), .GAP_CYCLES(3), .ACK_TIMEOUT(16)) u_b (
        .clock(clock), .reset(reset), .bus(ifb.slave));
    uart_word_tx #(.WORD_BYTES(2), .GAP_CYCLES(3), .ACK_TIMEOUT(16)) u_c (
        .clock(clock), .reset(reset), .bus(ifc.slave));

    // uart core models: busy for len clocks starting the clock after tx_start
    int len_a = 10;
    int len_b = 5;
    int len_c = 5;
    bit en_a  = 1'b1;
    int cnt_a, cnt_b, cnt_c;

    always @(posedge clock or negedge reset)
        if (!reset) cnt_a <= 0;
        else if (ifa.tx_start && en_a) cnt_a <= len_a;
        else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    always @(posedge clock or negedge reset)
        if (!reset) cnt_b <= 0;
        else if (ifb.tx_start) cnt_b <= len_b;
        else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    always @(posedge clock or negedge reset)
        if (!reset) cnt_c <= 0;
        else if (ifc.tx_start) cnt_c <= len_c;
        else if (cnt_c != 0) cnt_c <= cnt_c - 1;

    assign ifa.uart_busy = (cnt_a != 0);
    assign ifb.uart_busy = (cnt_b != 0);
    assign ifc.uart_busy = (cnt_c != 0);

    // monitors
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];
    int stc_a[$];
    int stc_c[$];
    int fl_c[$];
    int st_a = 0, dn_a = 0, er_a = 0, dr_a = 0, er_cyc_a = 0;
    int st_b = 0, dn_b = 0, st_c = 0, dn_c = 0;
    bit prev_ub_c = 1'b0;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            if (ifa.tx_start) begin
                q_a.push_back(ifa.tx_byte);
                stc_a.push_back(cyc);
                st_a++;
            end
            if (ifa.done) dn_a++;
            if (ifa.error) begin
                er_a++;
                er_cyc_a = cyc;
            end
            if (ifa.send_dropped) dr_a++;
            if (ifb.tx_start) begin
                q_b.push_back(ifb.tx_byte);
                st_b++;
            end
            if (ifb.done) dn_b++;
            if (prev_ub_c && !ifc.uart_busy) fl_c.push_back(cyc);
            prev_ub_c = ifc.uart_busy;
            if (ifc.tx_start) begin
                q_c.push_back(ifc.tx_byte);
                stc_c.push_back(cyc);
                st_c++;
            end
            if (ifc.done) dn_c++;
        end
    end

    // reference: byte i of an nb-byte word, MSB byte first
    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i, input int nb);
        logic [31:0] t;
        t = w >> (8 * (nb - 1 - i));
        return t[7:0];
    endfunction

    task automatic send_a(input logic [31:0] w);
        ifa.word_in = w;
        ifa.send    = 1'b1;
        @(negedge clock);
        ifa.send    = 1'b0;
    endtask

    task automatic wait_a(input int budget, input bit rxr, output int low, output bit ok);
        ok  = 1'b0;
        low = 0;
        for (int i = 0; i < budget; i++) begin
            if (rxr) ifa.rx_active = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            if (ifa.done || ifa.error) begin
                ok = 1'b1;
                break;
            end
            if (!ifa.busy) low++;
        end
        ifa.rx_active = 1'b0;
    endtask

    task automatic test_reset;
        logic [12:0] o;
        int s0;
        repeat (3) @(negedge clock);
        total++;
        o = {ifa.busy, ifa.done, ifa.error, ifa.send_dropped, ifa.tx_start, ifa.tx_byte};
        if (o !== 13'h0) begin
            bad++;
            $display("FAIL reset_a got=%h want=%h", o, 13'h0);
        end
        total++;
        o = {ifc.busy, ifc.done, ifc.error, ifc.send_dropped, ifc.tx_start, ifc.tx_byte};
        if (o !== 13'h0) begin
            bad++;
            $display("FAIL reset_c got=%h want=%h", o, 13'h0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        en_a = 1'b0;
        send_a(32'hA5C3_0F1E);
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        total++;
        o = {ifa.busy, ifa.done, ifa.error, ifa.send_dropped, ifa.tx_start, ifa.tx_byte};
        if (o !== 13'h0) begin
            bad++;
            $display("FAIL reset_mid_ack got=%h want=%h", o, 13'h0);
        end
        @(negedge clock);
        reset = 1'b1;
        en_a  = 1'b1;
        s0    = st_a;
        repeat (20) @(negedge clock);
        total++;
        if (st_a != s0) begin
            bad++;
            $display("FAIL reset_no_strobe got=%0d want=%0d", st_a - s0, 0);
        end
        total++;
        if (ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy got=%b want=0", ifa.busy);
        end
    endtask

    task automatic test_basic;
        int qs, s0, d0, low;
        bit ok;
        logic [31:0] w;
        w  = 32'h1234_5678;
        qs = q_a.size();
        s0 = st_a;
        d0 = dn_a;
        len_a = 10;
        send_a(w);
        wait_a(400, 1'b0, low, ok);
        @(negedge clock);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout got=%b want=1", ok);
        end
        total++;
        if (low != 0) begin
            bad++;
            $display("FAIL basic_busy_low got=%0d want=0", low);
        end
        total++;
        if (st_a - s0 != 4) begin
            bad++;
            $display("FAIL basic_strobes got=%0d want=4", st_a - s0);
        end
        total++;
        if (dn_a - d0 != 1) begin
            bad++;
            $display("FAIL basic_done got=%0d want=1", dn_a - d0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_a.size() <= qs + i || q_a[qs+i] !== byte_of(w, i, 4)) begin
                bad++;
                $display("FAIL basic_byte%0d got=%h want=%h", i,
                         (q_a.size() > qs + i) ? q_a[qs+i] : 8'hxx, byte_of(w, i, 4));
            end
        end
        total++;
        if (ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_after got=%b want=0", ifa.busy);
        end
    endtask

    task automatic test_rx_defer;
        int qs, s0, fall, low;
        bit ok;
        logic [31:0] w;
        w  = $urandom;
        qs = q_a.size();
        s0 = st_a;
        len_a = $urandom_range(1, 12);
        ifa.rx_active = 1'b1;
        send_a(w);
        repeat (49) @(negedge clock);
        total++;
        if (st_a != s0) begin
            bad++;
            $display("FAIL rx_hold_strobe got=%0d want=0", st_a - s0);
        end
        ifa.rx_active = 1'b0;
        fall = cyc;
        wait_a(2000, 1'b1, low, ok);
        @(negedge clock);
        total++;
        if (!ok || st_a - s0 != 4) begin
            bad++;
            $display("FAIL rx_strobes got=%0d want=4", st_a - s0);
        end
        total++;
        if (stc_a.size() <= qs || stc_a[qs] <= fall) begin
            bad++;
            $display("FAIL rx_first_start got=%0d want>%0d",
                     (stc_a.size() > qs) ? stc_a[qs] : -1, fall);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_a.size() <= qs + i || q_a[qs+i] !== byte_of(w, i, 4)) begin
                bad++;
                $display("FAIL rx_byte%0d got=%h want=%h", i,
                         (q_a.size() > qs + i) ? q_a[qs+i] : 8'hxx, byte_of(w, i, 4));
            end
        end
    endtask

    task automatic test_dropped;
        int qs, s0, d0, r0, low;
        bit ok, seen;
        logic [31:0] w;
        w  = 32'h1234_5678;
        qs = q_a.size();
        s0 = st_a;
        d0 = dn_a;
        r0 = dr_a;
        len_a = 10;
        send_a(w);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (st_a - s0 >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL drop_byte2_wait got=%0d want=2", st_a - s0);
        end
        send_a(32'hDEAD_BEEF);
        wait_a(400, 1'b0, low, ok);
        @(negedge clock);
        total++;
        if (dr_a - r0 != 1) begin
            bad++;
            $display("FAIL drop_pulse got=%0d want=1", dr_a - r0);
        end
        total++;
        if (!ok || dn_a - d0 != 1 || st_a - s0 != 4) begin
            bad++;
            $display("FAIL drop_done got=%0d/%0d want=1/4", dn_a - d0, st_a - s0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (q_a.size() <= qs + i || q_a[qs+i] !== byte_of(w, i, 4)) begin
                bad++;
                $display("FAIL drop_byte%0d got=%h want=%h", i,
                         (q_a.size() > qs + i) ? q_a[qs+i] : 8'hxx, byte_of(w, i, 4));
            end
        end
        total++;
        if (ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_busy_after got=%b want=0", ifa.busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ws[6];
        int qs, d0, r0, low, fails;
        bit ok;
        qs    = q_a.size();
        d0    = dn_a;
        r0    = dr_a;
        fails = 0;
        for (int k = 0; k < 6; k++) begin
            ws[k] = $urandom;
            len_a = $urandom_range(1, 8);
            // next word goes in on the very cycle done is seen
            send_a(ws[k]);
            wait_a(1000, k[0], low, ok);
            if (!ok) fails++;
        end
        @(negedge clock);
        total++;
        if (fails != 0 || dn_a - d0 != 6) begin
            bad++;
            $display("FAIL b2b_done got=%0d want=6", dn_a - d0);
        end
        total++;
        if (dr_a != r0) begin
            bad++;
            $display("FAIL b2b_dropped got=%0d want=0", dr_a - r0);
        end
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q_a.size() <= qs + 4*k + i || q_a[qs+4*k+i] !== byte_of(ws[k], i, 4)) begin
                    bad++;
                    $display("FAIL b2b_w%0d_b%0d got=%h want=%h", k, i,
                             (q_a.size() > qs + 4*k + i) ? q_a[qs+4*k+i] : 8'hxx,
                             byte_of(ws[k], i, 4));
                end
            end
        end
    endtask

    task automatic test_timeout;
        int s0, d0, e0, low;
        bit ok;
        s0   = st_a;
        d0   = dn_a;
        e0   = er_a;
        en_a = 1'b0;
        send_a($urandom);
        wait_a(100, 1'b0, low, ok);
        @(negedge clock);
        total++;
        if (!ok || er_a - e0 != 1) begin
            bad++;
            $display("FAIL to_error got=%0d want=1", er_a - e0);
        end
        total++;
        if (dn_a != d0) begin
            bad++;
            $display("FAIL to_no_done got=%0d want=0", dn_a - d0);
        end
        total++;
        if (stc_a.size() == 0 || er_cyc_a - stc_a[stc_a.size()-1] != 16) begin
            bad++;
            $display("FAIL to_delay got=%0d want=16",
                     (stc_a.size() > 0) ? er_cyc_a - stc_a[stc_a.size()-1] : -1);
        end
        total++;
        if (ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL to_busy got=%b want=0", ifa.busy);
        end
        repeat (30) @(negedge clock);
        total++;
        if (st_a - s0 != 1) begin
            bad++;
            $display("FAIL to_strobes got=%0d want=1", st_a - s0);
        end
        en_a = 1'b1;
    endtask

    task automatic test_gap;
        logic [7:0]  wb;
        logic [15:0] wc;
        int qs, s0, d0, fs;
        bit ok;
        wb = 8'($urandom);
        qs = q_b.size();
        s0 = st_b;
        d0 = dn_b;
        ifb.word_in = wb;
        ifb.send    = 1'b1;
        @(negedge clock);
        ifb.send = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (ifb.done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
        total++;
        if (!ok || st_b - s0 != 1 || dn_b - d0 != 1) begin
            bad++;
            $display("FAIL gap_w1_count got=%0d/%0d want=1/1", st_b - s0, dn_b - d0);
        end
        total++;
        if (q_b.size() <= qs || q_b[qs] !== wb) begin
            bad++;
            $display("FAIL gap_w1_byte got=%h want=%h",
                     (q_b.size() > qs) ? q_b[qs] : 8'hxx, wb);
        end

        wc = 16'($urandom);
        qs = q_c.size();
        fs = fl_c.size();
        s0 = st_c;
        d0 = dn_c;
        ifc.word_in = wc;
        ifc.send    = 1'b1;
        @(negedge clock);
        ifc.send = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (ifc.done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
        total++;
        if (!ok || st_c - s0 != 2 || dn_c - d0 != 1) begin
            bad++;
            $display("FAIL gap_w2_count got=%0d/%0d want=2/1", st_c - s0, dn_c - d0);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (q_c.size() <= qs + i || q_c[qs+i] !== byte_of({16'h0, wc}, i, 2)) begin
                bad++;
                $display("FAIL gap_w2_byte%0d got=%h want=%h", i,
                         (q_c.size() > qs + i) ? q_c[qs+i] : 8'hxx,
                         byte_of({16'h0, wc}, i, 2));
            end
        end
        total++;
        if (stc_c.size() < qs + 2 || fl_c.size() <= fs
            || stc_c[qs+1] - fl_c[fs] < 4) begin
            bad++;
            $display("FAIL gap_w2_idle got=%0d want>=4",
                     (stc_c.size() >= qs + 2 && fl_c.size() > fs)
                     ? stc_c[qs+1] - fl_c[fs] : -1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.word_in   = '0;
        ifa.send      = 1'b0;
        ifa.rx_active = 1'b0;
        ifb.word_in   = '0;
        ifb.send      = 1'b0;
        ifb.rx_active = 1'b0;
        ifc.word_in   = '0;
        ifc.send      = 1'b0;
        ifc.rx_active = 1'b0;
        reset         = 1'b0;
        @(negedge clock);
        test_reset;
        test_basic;
        test_rx_defer;
        test_dropped;
        test_back_to_back;
        test_timeout;
        test_gap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
